// File: rtl/bs_fsk_ctrl_if.sv
// ============================================================================
// bs_fsk_ctrl_if : byte-source handshake and RF-switch signals of bs_fsk_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bs_fsk_ctrl_if;
  logic       start;
  logic [7:0] frame_len;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       sc_out;
  logic       busy;
  logic       done;
  logic       underrun;

  modport master (
    output start, frame_len, byte_data, byte_valid,
    input  byte_ready, sc_out, busy, done, underrun
  );

  modport slave (
    input  start, frame_len, byte_data, byte_valid,
    output byte_ready, sc_out, busy, done, underrun
  );
endinterface

`default_nettype wire

// File: rtl/bs_fsk_ctrl.sv
// ============================================================================
// bs_fsk_ctrl : backscatter FSK frame sequencer (preamble, payload, guard gap)
// Revision: 1.0
// ============================================================================
`default_nettype none

module bs_fsk_ctrl #(
  parameter int          DIV_ONE    = 3,
  parameter int          DIV_ZERO   = 6,
  parameter int          BIT_CYCLES = 96,
  parameter int          PRE_LEN    = 8,
  parameter logic [15:0] PREAMBLE   = 16'h00A5,
  parameter int          GAP_CYCLES = 32
) (
  input  wire logic clk_in,
  input  wire logic rst_in,
  bs_fsk_ctrl_if.slave bus
);

  localparam int c_DIV_MAX = (DIV_ONE > DIV_ZERO) ? DIV_ONE : DIV_ZERO;
  localparam int c_PW      = $clog2(c_DIV_MAX) + 1;
  localparam int c_BW      = $clog2(BIT_CYCLES) + 1;
  localparam int c_GW      = $clog2(GAP_CYCLES) + 1;
  localparam int c_SW      = 5;

  localparam logic [c_PW-1:0] c_ONE_LAST  = c_PW'(DIV_ONE - 1);
  localparam logic [c_PW-1:0] c_ZERO_LAST = c_PW'(DIV_ZERO - 1);
  localparam logic [c_PW-1:0] c_PH_INC    = c_PW'(1);
  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(BIT_CYCLES - 1);
  localparam logic [c_BW-1:0] c_BIT_INC   = c_BW'(1);
  localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(GAP_CYCLES - 1);
  localparam logic [c_GW-1:0] c_GAP_INC   = c_GW'(1);
  localparam logic [c_SW-1:0] c_PRE_LAST  = c_SW'(PRE_LEN - 1);
  localparam logic [c_SW-1:0] c_BYTE_LAST = c_SW'(7);
  localparam logic [c_SW-1:0] c_SYM_INC   = c_SW'(1);
  // Preamble field left-aligned so the symbol to send is always bit 15
  localparam logic [15:0]     c_PRE_ALIGN = PREAMBLE << (16 - PRE_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]      r_state;
  logic            r_sc;
  logic [c_PW-1:0] r_ph;
  logic [c_BW-1:0] r_bcnt;
  logic [c_SW-1:0] r_sym;
  logic [c_GW-1:0] r_gcnt;
  logic [7:0]      r_len;
  logic [7:0]      r_shift;
  logic [15:0]     r_pre;
  logic            r_uflow;

  logic            w_slot_first;
  logic            w_accept;
  logic            w_underrun;
  logic            w_bit;
  logic [c_PW-1:0] w_div_last;
  logic            w_ph_wrap;
  logic            w_sym_end;
  logic [c_PW-1:0] w_ph_next;
  logic            w_sc_next;
  logic [c_BW-1:0] w_bcnt_next;
  logic            w_gap_last;

  assign w_slot_first = (r_state == S_DATA) && (r_bcnt == '0) && (r_sym == '0);
  assign w_accept     = w_slot_first &&  bus.byte_valid;
  assign w_underrun   = w_slot_first && !bus.byte_valid;

  // The first cycle of a byte slot already transmits bit 7 straight off the bus
  assign w_bit = (r_state == S_PRE) ? r_pre[15] :
                 (w_slot_first ? bus.byte_data[7] : r_shift[7]);

  assign w_div_last  = w_bit ? c_ONE_LAST : c_ZERO_LAST;
  assign w_ph_wrap   = (r_ph == w_div_last);
  assign w_sym_end   = (r_bcnt == c_BIT_LAST);
  assign w_ph_next   = (w_sym_end || w_ph_wrap) ? '0 : r_ph + c_PH_INC;
  assign w_sc_next   = w_ph_wrap ? ~r_sc : r_sc;
  assign w_bcnt_next = w_sym_end ? '0 : r_bcnt + c_BIT_INC;
  assign w_gap_last  = (r_state == S_GAP) && (r_gcnt == c_GAP_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_sc    <= 1'b0;
      r_ph    <= '0;
      r_bcnt  <= '0;
      r_sym   <= '0;
      r_gcnt  <= '0;
      r_len   <= '0;
      r_shift <= '0;
      r_pre   <= '0;
      r_uflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sc   <= 1'b0;
          r_ph   <= '0;
          r_bcnt <= '0;
          r_sym  <= '0;
          r_gcnt <= '0;
          if (bus.start && (bus.frame_len != 8'd0)) begin
            r_len   <= bus.frame_len;
            r_pre   <= c_PRE_ALIGN;
            r_uflow <= 1'b0;
            r_state <= S_PRE;
          end
        end

        S_PRE: begin
          r_sc   <= w_sc_next;
          r_ph   <= w_ph_next;
          r_bcnt <= w_bcnt_next;
          if (w_sym_end) begin
            r_pre <= {r_pre[14:0], 1'b0};
            if (r_sym == c_PRE_LAST) begin
              r_sym   <= '0;
              r_state <= S_DATA;
            end else begin
              r_sym <= r_sym + c_SYM_INC;
            end
          end
        end

        S_DATA: begin
          if (w_underrun) begin
            r_sc    <= 1'b0;
            r_ph    <= '0;
            r_bcnt  <= '0;
            r_sym   <= '0;
            r_gcnt  <= '0;
            r_uflow <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_sc   <= w_sc_next;
            r_ph   <= w_ph_next;
            r_bcnt <= w_bcnt_next;
            if (w_accept) begin
              r_shift <= bus.byte_data;
              r_len   <= r_len - 8'd1;
            end else if (w_sym_end) begin
              r_shift <= {r_shift[6:0], 1'b0};
            end
            if (w_sym_end) begin
              if (r_sym == c_BYTE_LAST) begin
                r_sym <= '0;
                // r_len already counts the byte just finished
                if (r_len == 8'd0) begin
                  r_sc    <= 1'b0;
                  r_ph    <= '0;
                  r_gcnt  <= '0;
                  r_state <= S_GAP;
                end
              end else begin
                r_sym <= r_sym + c_SYM_INC;
              end
            end
          end
        end

        S_GAP: begin
          r_sc <= 1'b0;
          if (w_gap_last) begin
            r_gcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + c_GAP_INC;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The underrun cycle must already be silent on the switch pin
  assign bus.sc_out     = r_sc & ~w_underrun;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = w_gap_last & ~r_uflow;
  assign bus.underrun   = w_underrun;
  assign bus.byte_ready = w_slot_first;

endmodule

`default_nettype wire

// File: tb/tb_bs_fsk_ctrl.sv
// ============================================================================
// tb_bs_fsk_ctrl : table-driven frame checks for bs_fsk_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bs_fsk_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bs_fsk_ctrl_if bus();

  bs_fsk_ctrl #(
    .DIV_ONE   (2),
    .DIV_ZERO  (4),
    .BIT_CYCLES(16),
    .PRE_LEN   (8),
    .PREAMBLE  (16'h00A5),
    .GAP_CYCLES(10)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  typedef struct {
    int          len;
    logic [23:0] bytes;
    int          bad;
    int          restart;
  } frame_t;

  frame_t tbl[6];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int cyc, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic logic pre_bit(input int i);
    logic [7:0] p;
    p = 8'hA5;
    return p[7-i];
  endfunction

  task automatic run_frame(input frame_t f);
    int   slot, u, last_busy, sym_end, ncyc, sym, o, h, k;
    logic normal, b, e_sc, e_br, e_busy, e_un, e_done;
    logic [7:0] bv;
    slot   = 0;
    u      = -1;
    normal = (f.bad < 0) || (f.bad >= f.len);
    if (f.len == 0) begin
      last_busy = 0; sym_end = 0;
    end else if (!normal) begin
      u = 129 + 128 * f.bad; sym_end = u - 1; last_busy = u + 10;
    end else begin
      sym_end = 128 + 128 * f.len; last_busy = sym_end + 10;
    end
    ncyc = ((last_busy > 20) ? last_busy : 20) + 3;
    for (int c = 0; c < ncyc; c++) begin
      bus.start     = (c == 0) || (c == f.restart);
      bus.frame_len = (c == 0) ? 8'(f.len) : 8'd7;
      if (bus.byte_ready && slot < 3) begin
        bus.byte_valid = (slot != f.bad);
        bus.byte_data  = f.bytes[23-8*slot -: 8];
        slot++;
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
      end
      @(negedge clk);
      e_busy = (f.len != 0) && (c >= 1) && (c <= last_busy);
      e_sc   = 1'b0;
      if (f.len != 0 && c >= 1 && c <= sym_end) begin
        sym = (c - 1) / 16;
        o   = (c - 1) % 16;
        if (sym < 8) begin
          b = pre_bit(sym);
        end else begin
          k  = (sym - 8) / 8;
          bv = f.bytes[23-8*k -: 8];
          b  = bv[7 - ((sym - 8) % 8)];
        end
        h    = b ? 2 : 4;
        e_sc = ((o / h) % 2) == 1;
      end
      e_br = (f.len != 0) && (c >= 129) && (((c - 129) % 128) == 0) &&
             (((c - 129) / 128) < f.len) && (normal || ((c - 129) / 128) <= f.bad);
      e_un   = !normal && (c == u);
      e_done = normal && (f.len != 0) && (c == last_busy);
      chk("sc_out",     c, bus.sc_out,     e_sc);
      chk("byte_ready", c, bus.byte_ready, e_br);
      chk("busy",       c, bus.busy,       e_busy);
      chk("underrun",   c, bus.underrun,   e_un);
      chk("done",       c, bus.done,       e_done);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.frame_len  = 8'd0;
    bus.byte_data  = 8'd0;
    bus.byte_valid = 1'b0;
    rst            = 1'b1;

    tbl[0] = '{len: 1, bytes: 24'hFF0000, bad: -1, restart: -1};
    tbl[1] = '{len: 3, bytes: 24'h00813C, bad: -1, restart: -1};
    tbl[2] = '{len: 2, bytes: 24'hC35500, bad:  1, restart: -1};
    tbl[3] = '{len: 0, bytes: 24'hFFFFFF, bad: -1, restart: -1};
    tbl[4] = '{len: 1, bytes: 24'h6B0000, bad: -1, restart: 140};
    tbl[5] = '{len: 2, bytes: 24'hC31800, bad: -1, restart: 60};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst sc_out",     0, bus.sc_out,     1'b0);
    chk("rst byte_ready", 0, bus.byte_ready, 1'b0);
    chk("rst busy",       0, bus.busy,       1'b0);
    chk("rst underrun",   0, bus.underrun,   1'b0);
    chk("rst done",       0, bus.done,       1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // Reset pulsed in the middle of the first payload byte
    for (int c = 0; c <= 200; c++) begin
      bus.start      = (c == 0);
      bus.frame_len  = 8'd2;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h96;
      if (c == 200) begin
        rst = 1'b1;
        @(negedge clk);
        chk("pre-reset busy", c, bus.busy, 1'b1);
      end
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("post-reset sc_out",     201, bus.sc_out,     1'b0);
    chk("post-reset byte_ready", 201, bus.byte_ready, 1'b0);
    chk("post-reset underrun",   201, bus.underrun,   1'b0);
    for (int c = 201; c < 221; c++) begin
      if (c != 201) @(negedge clk);
      chk("post-reset busy", c, bus.busy, 1'b0);
      chk("post-reset done", c, bus.done, 1'b0);
      @(posedge clk); #1;
    end

    run_frame(tbl[5]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
